// File: rtl/bin_counter_checker_pkg.sv
// Shared types and helpers for the binary counter checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: checker FSM state encoding and a saturating-increment helper.
package bin_counter_checker_pkg;

   typedef enum logic [1:0] {
      ST_SYNC  = 2'd0,
      ST_ARMED = 2'd1,
      ST_FAULT = 2'd2
   } chk_state_e;

   // Increment v, holding at the all-ones value of a w-bit counter (w <= 32).
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
      logic [31:0] top;
      top = 32'hFFFF_FFFF >> (32 - w);
      return (v >= top) ? top : v + 32'd1;
   endfunction

endpackage

// File: rtl/bin_counter_checker_if.sv
// Snoop bundle: counter controls, counter outputs under check, and the resync pulse.
// Latency: n/a (wires only).
// Backpressure: none; the checker observes and never stalls the counter.
// master: stimulus side drives everything; slave: checker samples everything.
interface bin_counter_checker_if #(
   parameter int N = 8
);
   logic         syn_clr;
   logic         load;
   logic         en;
   logic         up;
   logic [N-1:0] d;
   logic [N-1:0] q;
   logic         max_tick;
   logic         min_tick;
   logic         resync;

   modport master (output syn_clr, load, en, up, d, q, max_tick, min_tick, resync);
   modport slave  (input  syn_clr, load, en, up, d, q, max_tick, min_tick, resync);
endinterface

// File: rtl/bin_counter_checker_ref_model.sv
// Golden next-value function of the universal binary counter.
// Latency: combinational.
// Backpressure: none.
// Ports: v (current value), syn_clr/load/en/up/d (controls) -> nv (next value, mod 2^N).
module bin_ref_model #(
   parameter int N = 8
) (
   input  logic [N-1:0] v,
   input  logic         syn_clr,
   input  logic         load,
   input  logic         en,
   input  logic         up,
   input  logic [N-1:0] d,
   output logic [N-1:0] nv
);
   // Priority: clear, then load, then count; wrap-around is natural modulo arithmetic.
   always_comb begin
      nv = v;
      if (syn_clr)
         nv = '0;
      else if (load)
         nv = d;
      else if (en && up)
         nv = v + N'(1);
      else if (en)
         nv = v - N'(1);
   end
endmodule

// File: rtl/bin_counter_checker.sv
// Cycle-by-cycle checker of a binary counter's q/max_tick/min_tick against a reference model.
// Latency: verdict (err, err_pulse, counts, snapshots) visible one cycle after the sampled edge.
// Backpressure: none; purely an observer.
// Ports: clk, reset (sync, active-high); bus (snooped controls + outputs, resync);
//        armed, err, err_pulse, err_cnt, chk_cnt, exp_q, first_bad_q, first_bad_exp.
module bin_counter_checker
   import bin_counter_checker_pkg::*;
#(
   parameter int N             = 8,
   parameter int CW            = 16,
   parameter bit STOP_ON_ERR   = 1'b0,
   parameter bit RESYNC_ON_ERR = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   bin_counter_checker_if.slave   bus,
   output logic                   armed,
   output logic                   err,
   output logic                   err_pulse,
   output logic [CW-1:0]          err_cnt,
   output logic [CW-1:0]          chk_cnt,
   output logic [N-1:0]           exp_q,
   output logic [N-1:0]           first_bad_q,
   output logic [N-1:0]           first_bad_exp
);
   localparam logic [N-1:0] Q_MAX = '1;

   chk_state_e    state_q, state_d;
   logic          err_q, err_d;
   logic          err_pulse_q, err_pulse_d;
   logic [CW-1:0] err_cnt_q, err_cnt_d;
   logic [CW-1:0] chk_cnt_q, chk_cnt_d;
   logic [N-1:0]  exp_q_q, exp_q_d;
   logic [N-1:0]  first_bad_q_q, first_bad_q_d;
   logic [N-1:0]  first_bad_exp_q, first_bad_exp_d;

   logic [N-1:0]  nxt_obs;   // next value predicted from the observed q
   logic [N-1:0]  nxt_exp;   // next value predicted from the model's own value
   logic          mismatch;

   bin_ref_model #(.N(N)) u_ref_obs (
      .v(bus.q), .syn_clr(bus.syn_clr), .load(bus.load), .en(bus.en), .up(bus.up),
      .d(bus.d), .nv(nxt_obs)
   );

   bin_ref_model #(.N(N)) u_ref_exp (
      .v(exp_q_q), .syn_clr(bus.syn_clr), .load(bus.load), .en(bus.en), .up(bus.up),
      .d(bus.d), .nv(nxt_exp)
   );

   // Ticks are checked against the observed q, so a bad q does not also flag the ticks.
   always_comb begin
      mismatch = (bus.q != exp_q_q)
              || (bus.max_tick != (bus.q == Q_MAX))
              || (bus.min_tick != (bus.q == '0));
   end

   always_comb begin
      state_d         = state_q;
      err_d           = err_q;
      err_pulse_d     = 1'b0;
      err_cnt_d       = err_cnt_q;
      chk_cnt_d       = chk_cnt_q;
      exp_q_d         = exp_q_q;
      first_bad_q_d   = first_bad_q_q;
      first_bad_exp_d = first_bad_exp_q;

      case (state_q)
         ST_FAULT: begin
            // Frozen until reset; resync is deliberately ignored here.
         end
         ST_ARMED: begin
            if (bus.resync) begin
               exp_q_d = nxt_obs;
            end else begin
               chk_cnt_d = CW'(sat_inc(32'(chk_cnt_q), CW));
               if (mismatch) begin
                  err_pulse_d = 1'b1;
                  err_d       = 1'b1;
                  err_cnt_d   = CW'(sat_inc(32'(err_cnt_q), CW));
                  if (!err_q) begin
                     first_bad_q_d   = bus.q;
                     first_bad_exp_d = exp_q_q;
                  end
                  exp_q_d = RESYNC_ON_ERR ? nxt_obs : nxt_exp;
                  if (STOP_ON_ERR)
                     state_d = ST_FAULT;
               end else begin
                  exp_q_d = nxt_exp;
               end
            end
         end
         default: begin
            // SYNC (and any illegal encoding): adopt the observed counter, start checking.
            exp_q_d = nxt_obs;
            state_d = ST_ARMED;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= ST_SYNC;
         err_q           <= 1'b0;
         err_pulse_q     <= 1'b0;
         err_cnt_q       <= '0;
         chk_cnt_q       <= '0;
         exp_q_q         <= '0;
         first_bad_q_q   <= '0;
         first_bad_exp_q <= '0;
      end else begin
         state_q         <= state_d;
         err_q           <= err_d;
         err_pulse_q     <= err_pulse_d;
         err_cnt_q       <= err_cnt_d;
         chk_cnt_q       <= chk_cnt_d;
         exp_q_q         <= exp_q_d;
         first_bad_q_q   <= first_bad_q_d;
         first_bad_exp_q <= first_bad_exp_d;
      end
   end

   assign armed         = (state_q == ST_ARMED);
   assign err           = err_q;
   assign err_pulse     = err_pulse_q;
   assign err_cnt       = err_cnt_q;
   assign chk_cnt       = chk_cnt_q;
   assign exp_q         = exp_q_q;
   assign first_bad_q   = first_bad_q_q;
   assign first_bad_exp = first_bad_exp_q;
endmodule

// File: tb/tb_bin_counter_checker.sv
module tb_bin_counter_checker;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   bin_counter_checker_if #(.N(8)) bus ();

   // Instance 0: defaults. Instance 1: stop on error. Instance 2: 2-bit counters, no resync on error.
   logic        armed0, err0, pulse0, armed1, err1, pulse1, armed2, err2, pulse2;
   logic [15:0] ecnt0, ccnt0, ecnt1, ccnt1;
   logic [1:0]  ecnt2, ccnt2;
   logic [7:0]  expq0, fbq0, fbe0, expq1, fbq1, fbe1, expq2, fbq2, fbe2;

   bin_counter_checker #(.N(8), .CW(16), .STOP_ON_ERR(1'b0), .RESYNC_ON_ERR(1'b1)) u_dut0 (
      .clk(clk), .reset(reset), .bus(bus.slave),
      .armed(armed0), .err(err0), .err_pulse(pulse0), .err_cnt(ecnt0), .chk_cnt(ccnt0),
      .exp_q(expq0), .first_bad_q(fbq0), .first_bad_exp(fbe0));

   bin_counter_checker #(.N(8), .CW(16), .STOP_ON_ERR(1'b1), .RESYNC_ON_ERR(1'b1)) u_dut1 (
      .clk(clk), .reset(reset), .bus(bus.slave),
      .armed(armed1), .err(err1), .err_pulse(pulse1), .err_cnt(ecnt1), .chk_cnt(ccnt1),
      .exp_q(expq1), .first_bad_q(fbq1), .first_bad_exp(fbe1));

   bin_counter_checker #(.N(8), .CW(2), .STOP_ON_ERR(1'b0), .RESYNC_ON_ERR(1'b0)) u_dut2 (
      .clk(clk), .reset(reset), .bus(bus.slave),
      .armed(armed2), .err(err2), .err_pulse(pulse2), .err_cnt(ecnt2), .chk_cnt(ccnt2),
      .exp_q(expq2), .first_bad_q(fbq2), .first_bad_exp(fbe2));

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, want);
      end
   endtask

   // Stimulus state: counter controls, the ideal counter value, and tick corruption flags.
   bit s_rst, s_clr, s_load, s_en, s_up, s_resync, flip_max, flip_min;
   int s_d, cnt;

   // Reference model per instance.
   int p_stop[3]   = '{0, 1, 0};
   int p_resync[3] = '{1, 1, 0};
   int p_cw[3]     = '{16, 16, 2};
   bit m_live[3], m_frozen[3], m_err[3], m_pulse[3];
   int m_ecnt[3], m_ccnt[3], m_exp[3], m_fbq[3], m_fbe[3];

   function automatic int nxt(input int v);
      if (s_clr)  return 0;
      if (s_load) return s_d;
      if (s_en)   return s_up ? (v + 1) % 256 : (v + 255) % 256;
      return v;
   endfunction

   task automatic model_step(input int i, input int qv, input bit mx, input bit mn);
      bit bad;
      int top;
      top = (1 << p_cw[i]) - 1;
      if (s_rst) begin
         m_live[i] = 0; m_frozen[i] = 0; m_err[i] = 0; m_pulse[i] = 0;
         m_ecnt[i] = 0; m_ccnt[i] = 0; m_exp[i] = 0; m_fbq[i] = 0; m_fbe[i] = 0;
         return;
      end
      m_pulse[i] = 0;
      if (m_frozen[i]) return;
      if (s_resync || !m_live[i]) begin
         m_exp[i]  = nxt(qv);
         m_live[i] = 1;
         return;
      end
      bad = (qv != m_exp[i]) || (mx != (qv == 255)) || (mn != (qv == 0));
      if (m_ccnt[i] < top) m_ccnt[i]++;
      if (bad) begin
         if (!m_err[i]) begin
            m_fbq[i] = qv;
            m_fbe[i] = m_exp[i];
         end
         m_err[i]   = 1;
         m_pulse[i] = 1;
         if (m_ecnt[i] < top) m_ecnt[i]++;
         m_exp[i] = p_resync[i] ? nxt(qv) : nxt(m_exp[i]);
         if (p_stop[i]) begin
            m_frozen[i] = 1;
            m_live[i]   = 0;
         end
      end else begin
         m_exp[i] = nxt(m_exp[i]);
      end
   endtask

   task automatic cmp_inst(input int i, input logic a, input logic e, input logic p,
                           input logic [15:0] ec, input logic [15:0] cc,
                           input logic [7:0] x, input logic [7:0] fq, input logic [7:0] fe);
      chk($sformatf("u%0d.armed", i),         32'(a),  32'(m_live[i]));
      chk($sformatf("u%0d.err", i),           32'(e),  32'(m_err[i]));
      chk($sformatf("u%0d.err_pulse", i),     32'(p),  32'(m_pulse[i]));
      chk($sformatf("u%0d.err_cnt", i),       32'(ec), 32'(m_ecnt[i]));
      chk($sformatf("u%0d.chk_cnt", i),       32'(cc), 32'(m_ccnt[i]));
      chk($sformatf("u%0d.exp_q", i),         32'(x),  32'(m_exp[i]));
      chk($sformatf("u%0d.first_bad_q", i),   32'(fq), 32'(m_fbq[i]));
      chk($sformatf("u%0d.first_bad_exp", i), 32'(fe), 32'(m_fbe[i]));
   endtask

   // One clock: drive, advance model and ideal counter at the edge, check at the falling edge.
   task automatic tick();
      int  qv;
      bit  mx, mn;
      qv = cnt;
      mx = (cnt == 255) ^ flip_max;
      mn = (cnt == 0) ^ flip_min;
      reset        = s_rst;
      bus.syn_clr  = s_clr;
      bus.load     = s_load;
      bus.en       = s_en;
      bus.up       = s_up;
      bus.d        = 8'(s_d);
      bus.q        = 8'(qv);
      bus.max_tick = mx;
      bus.min_tick = mn;
      bus.resync   = s_resync;
      @(posedge clk);
      for (int i = 0; i < 3; i++) model_step(i, qv, mx, mn);
      cnt      = s_rst ? 0 : nxt(cnt);
      flip_max = 0;
      flip_min = 0;
      @(negedge clk);
      cmp_inst(0, armed0, err0, pulse0, ecnt0, ccnt0, expq0, fbq0, fbe0);
      cmp_inst(1, armed1, err1, pulse1, ecnt1, ccnt1, expq1, fbq1, fbe1);
      cmp_inst(2, armed2, err2, pulse2, 16'(ecnt2), 16'(ccnt2), expq2, fbq2, fbe2);
   endtask

   initial begin
      s_rst = 1; s_clr = 0; s_load = 0; s_en = 0; s_up = 0; s_d = 0; s_resync = 0;
      cnt = 0; flip_max = 0; flip_min = 0;
      tick();
      tick();
      chk("reset_armed", 32'(armed0), 32'd0);
      chk("reset_exp_q", 32'(expq0), 32'd0);

      // Correct counter counting up from 0 for 12 cycles.
      s_rst = 0; s_en = 1; s_up = 1;
      repeat (12) tick();
      chk("count_exp_q", 32'(expq0), 32'd12);
      chk("count_err", 32'(err0), 32'd0);
      chk("count_err_cnt", 32'(ecnt0), 32'd0);

      // Load 3, count up 2, then the counter jumps to 6.
      s_en = 0; s_load = 1; s_d = 8'h03;
      tick();
      s_load = 0; s_en = 1; s_up = 1;
      tick();
      tick();
      chk("load_up_exp_q", 32'(expq0), 32'd5);
      s_en = 0;
      cnt = 6;
      tick();
      chk("glitch_pulse", 32'(pulse0), 32'd1);
      chk("glitch_err_cnt", 32'(ecnt0), 32'd1);
      chk("glitch_first_bad_q", 32'(fbq0), 32'd6);
      chk("glitch_first_bad_exp", 32'(fbe0), 32'd5);
      tick();
      chk("glitch_pulse_drop", 32'(pulse0), 32'd0);
      s_en = 1;
      repeat (3) tick();
      chk("resynced_err_cnt", 32'(ecnt0), 32'd1);
      chk("resynced_err", 32'(err0), 32'd1);

      // max_tick wrong at FF, then a clean wrap FF -> 00.
      s_en = 0; s_load = 1; s_d = 8'hFF;
      tick();
      s_load = 0; flip_max = 1;
      tick();
      chk("max_tick_pulse", 32'(pulse0), 32'd1);
      chk("max_tick_err_cnt", 32'(ecnt0), 32'd2);
      s_en = 1; s_up = 1;
      tick();
      tick();
      chk("wrap_pulse", 32'(pulse0), 32'd0);
      chk("wrap_err_cnt", 32'(ecnt0), 32'd2);
      chk("wrap_exp_q", 32'(expq0), 32'd1);

      // Stop-on-error instance stays frozen; reset releases it.
      chk("fault_armed", 32'(armed1), 32'd0);
      chk("fault_err_cnt", 32'(ecnt1), 32'd1);
      s_rst = 1;
      tick();
      chk("fault_reset_armed", 32'(armed1), 32'd0);
      chk("fault_reset_err", 32'(err1), 32'd0);
      chk("fault_reset_err_cnt", 32'(ecnt1), 32'd0);
      s_rst = 0;
      tick();
      chk("fault_rearmed", 32'(armed1), 32'd1);

      // Clear beats load.
      s_clr = 1; s_load = 1; s_d = 8'hAA;
      tick();
      chk("clr_priority_exp_q", 32'(expq0), 32'd0);
      s_clr = 0; s_load = 0;
      cnt = (cnt + 7) % 256;
      tick();
      chk("pre_resync_err", 32'(err0), 32'd1);
      s_resync = 1;
      tick();
      chk("resync_keeps_err", 32'(err0), 32'd1);
      s_rst = 1;
      tick();
      chk("resync_reset_err", 32'(err0), 32'd0);
      chk("resync_reset_armed", 32'(armed0), 32'd0);
      s_rst = 0; s_resync = 0;
      tick();

      // Saturation of the 2-bit error counter.
      repeat (4) begin
         cnt = (cnt + 3) % 256;
         tick();
      end
      chk("sat_err_cnt", 32'(ecnt2), 32'd3);
      chk("sat_err", 32'(err2), 32'd1);

      // Randomized traffic with occasional glitches, resyncs and resets.
      repeat (500) begin
         s_rst    = ($urandom_range(0, 79) == 0);
         s_clr    = ($urandom_range(0, 15) == 0);
         s_load   = ($urandom_range(0, 7) == 0);
         s_en     = ($urandom_range(0, 3) != 0);
         s_up     = 1'($urandom);
         s_d      = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
         s_resync = ($urandom_range(0, 29) == 0);
         flip_max = ($urandom_range(0, 39) == 0);
         flip_min = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 19) == 0) cnt = $urandom_range(0, 255);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
